// File: rtl/trivium_rdi_if.sv
// Producer/consumer handshake carrying 128-bit keystream words.
interface trivium_rdi_if;
    logic [127:0] rdi_data;
    logic         rdi_valid;
    logic         rdi_ready;

    modport master (
        output rdi_data,
        output rdi_valid,
        input  rdi_ready
    );

    modport slave (
        input  rdi_data,
        input  rdi_valid,
        output rdi_ready
    );
endinterface

// File: rtl/trivium_rdi.sv
// Trivium keystream source: seed load, 1152-bit warm-up,
// then 128-bit words over the rdi handshake with one word of buffering.
module trivium_rdi #(
    parameter int BPC         = 32,
    parameter int WARMUP_BITS = 1152
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] seed,
    input  logic         reseed,
    trivium_rdi_if.master rdi
);
    localparam int NCH  = 128 / BPC;
    localparam int WCYC = WARMUP_BITS / BPC;
    localparam int FW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int WW   = $clog2(WCYC + 1);

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        RUN
    } state_t;

    state_t         state;
    logic [287:0]   st;
    logic [287:0]   s_nx;
    logic [287:0]   s_ld;
    logic [127:0]   acc;
    logic [127:0]   acc_nx;
    logic [BPC-1:0] z;
    logic [FW-1:0]  fill;
    logic [WW-1:0]  wcnt;
    logic           full;
    logic           t1;
    logic           t2;
    logic           t3;
    logic           xfer;
    logic           last;
    logic           unused_seed;

    // st[i-1] holds Trivium bit s_i
    always_comb begin
        s_ld          = '0;
        s_ld[79:0]    = seed[79:0];
        s_ld[172:93]  = seed[159:80];
        s_ld[287:285] = 3'b111;
    end

    assign unused_seed = ^seed[255:160];
    assign xfer = rdi.rdi_valid & rdi.rdi_ready;
    assign last = (fill == FW'(NCH - 1));

    always_comb begin
        s_nx = st;
        z    = '0;
        t1   = 1'b0;
        t2   = 1'b0;
        t3   = 1'b0;
        for (int i = 0; i < BPC; i++) begin
            t1 = s_nx[65] ^ s_nx[92];
            t2 = s_nx[161] ^ s_nx[176];
            t3 = s_nx[242] ^ s_nx[287];
            z[i] = t1 ^ t2 ^ t3;
            t1 = t1 ^ (s_nx[90] & s_nx[91]) ^ s_nx[170];
            t2 = t2 ^ (s_nx[174] & s_nx[175]) ^ s_nx[263];
            t3 = t3 ^ (s_nx[285] & s_nx[286]) ^ s_nx[68];
            s_nx = {s_nx[286:177], t2,
                    s_nx[175:93], t1,
                    s_nx[91:0], t3};
        end
    end

    always_comb begin
        acc_nx = acc;
        acc_nx[fill*BPC +: BPC] = z;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            st            <= '0;
            acc           <= '0;
            fill          <= '0;
            wcnt          <= '0;
            full          <= 1'b0;
            rdi.rdi_valid <= 1'b0;
            rdi.rdi_data  <= '0;
        end else if (reseed) begin
            state         <= WARMUP;
            st            <= s_ld;
            acc           <= '0;
            fill          <= '0;
            wcnt          <= '0;
            full          <= 1'b0;
            rdi.rdi_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: ;
                WARMUP: begin
                    st <= s_nx;
                    if (wcnt == WW'(WCYC - 1)) begin
                        state <= RUN;
                        wcnt  <= '0;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                RUN: begin
                    // a held word blocks the generator until it moves out
                    if (full) begin
                        if (xfer) begin
                            rdi.rdi_data <= acc;
                            full         <= 1'b0;
                        end
                    end else begin
                        st   <= s_nx;
                        fill <= last ? '0 : fill + 1'b1;
                        if (!last) begin
                            acc <= acc_nx;
                            if (xfer) rdi.rdi_valid <= 1'b0;
                        end else if (!rdi.rdi_valid || xfer) begin
                            rdi.rdi_data  <= acc_nx;
                            rdi.rdi_valid <= 1'b1;
                        end else begin
                            acc  <= acc_nx;
                            full <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
